// File: rtl/stack_op_sequencer_if.sv
// Control and stack-side signals of the RPN operation sequencer.
// Latency: none, wiring only.
// Backpressure: none; the sequencer paces itself with strobes and busy.
interface stack_op_sequencer_if #(
    parameter int WIDTH  = 32,
    parameter int SIZE_W = 10
);
    logic              start;
    logic [2:0]        op;
    logic              busy;
    logic              done;
    logic              err;
    logic [1:0]        err_code;
    logic [WIDTH-1:0]  stk_top;
    logic [SIZE_W-1:0] stk_size;
    logic              stk_error;
    logic              stk_push;
    logic              stk_pop;
    logic [WIDTH-1:0]  stk_in;

    modport master (
        output start, op, stk_top, stk_size, stk_error,
        input  busy, done, err, err_code, stk_push, stk_pop, stk_in
    );

    modport slave (
        input  start, op, stk_top, stk_size, stk_error,
        output busy, done, err, err_code, stk_push, stk_pop, stk_in
    );
endinterface

// File: rtl/stack_op_sequencer.sv
// Runs one RPN op on the operand stack: pops operands, computes, pushes result.
// Latency: DROP/DUP 2, ADD/SUB/MUL 6, SWAP 8, DIV/MOD 37 cycles start-to-done.
// Backpressure: start ignored while busy; stack strobes never on consecutive cycles.
module stack_op_sequencer #(
    parameter int WIDTH  = 32,
    parameter int SIZE_W = 10,
    parameter int DEPTH  = 1023
) (
    input  logic                 clk,
    input  logic                 reset_n,
    stack_op_sequencer_if.slave  bus
);
    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_WAIT_A = 4'd1;
    localparam logic [3:0] S_POP_B  = 4'd2;
    localparam logic [3:0] S_WAIT_B = 4'd3;
    localparam logic [3:0] S_EXEC   = 4'd4;
    localparam logic [3:0] S_DIV    = 4'd5;
    localparam logic [3:0] S_PUSH   = 4'd6;
    localparam logic [3:0] S_GAP    = 4'd7;
    localparam logic [3:0] S_PUSH_B = 4'd8;
    localparam logic [3:0] S_DONE   = 4'd9;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_DIV  = 3'b011;
    localparam logic [2:0] OP_MOD  = 3'b100;
    localparam logic [2:0] OP_DROP = 3'b101;
    localparam logic [2:0] OP_SWAP = 3'b110;
    localparam logic [2:0] OP_DUP  = 3'b111;

    localparam logic [SIZE_W-1:0] SZ_TWO   = SIZE_W'(2);
    localparam logic [SIZE_W-1:0] SZ_DEPTH = SIZE_W'(DEPTH);

    logic [3:0]       state;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a, b, result, quo, rem;
    logic [4:0]       cnt;
    logic             err_q;
    logic [1:0]       code_q;
    logic             stk_err_q;

    logic [1:0]       chk_code;
    logic             busy_st, err_rise;
    logic [WIDTH-1:0] alu, rem_in, q_in, rem_nx, q_nx;
    logic [WIDTH:0]   rem_sh;
    logic             div_ge;

    always_comb begin
        chk_code = 2'd0;
        unique case (bus.op)
            OP_DROP: if (bus.stk_size == '0) chk_code = 2'd1;
            OP_DUP: begin
                if (bus.stk_size == '0)            chk_code = 2'd1;
                else if (bus.stk_size >= SZ_DEPTH) chk_code = 2'd3;
            end
            default: begin
                if (bus.stk_size < SZ_TWO) chk_code = 2'd1;
                else if ((bus.op == OP_DIV || bus.op == OP_MOD) && bus.stk_top == '0)
                    chk_code = 2'd2;
            end
        endcase
    end

    assign busy_st  = (state != S_IDLE) && (state != S_DONE);
    assign err_rise = busy_st && bus.stk_error && !stk_err_q;

    always_comb begin
        alu = '0;
        unique case (op_q)
            OP_ADD:  alu = b + a;
            OP_SUB:  alu = b - a;
            default: alu = b * a;
        endcase
    end

    // Restoring divider step; the first of the 32 steps runs in EXEC from fresh operands.
    assign rem_in = (state == S_EXEC) ? '0 : rem;
    assign q_in   = (state == S_EXEC) ? b  : quo;
    assign rem_sh = {rem_in, q_in[WIDTH-1]};
    assign div_ge = rem_sh >= {1'b0, a};
    assign rem_nx = div_ge ? (rem_sh[WIDTH-1:0] - a) : rem_sh[WIDTH-1:0];
    assign q_nx   = {q_in[WIDTH-2:0], div_ge};

    assign bus.busy     = busy_st;
    assign bus.done     = (state == S_DONE);
    assign bus.err      = err_q;
    assign bus.err_code = code_q;
    assign bus.stk_in   = result;
    assign bus.stk_push = ((state == S_PUSH) || (state == S_PUSH_B)) && !err_rise;
    assign bus.stk_pop  = ((state == S_IDLE) && bus.start && (chk_code == 2'd0) && (bus.op != OP_DUP))
                        || ((state == S_POP_B) && !err_rise);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            op_q      <= '0;
            a         <= '0;
            b         <= '0;
            result    <= '0;
            quo       <= '0;
            rem       <= '0;
            cnt       <= '0;
            err_q     <= 1'b0;
            code_q    <= 2'd0;
            stk_err_q <= 1'b0;
        end else begin
            err_q     <= 1'b0;
            stk_err_q <= bus.stk_error;
            if (err_rise) begin
                state  <= S_IDLE;
                err_q  <= 1'b1;
                code_q <= 2'd3;
            end else begin
                unique case (state)
                    S_IDLE: if (bus.start) begin
                        code_q <= chk_code;
                        if (chk_code != 2'd0) begin
                            err_q <= 1'b1;
                        end else begin
                            a    <= bus.stk_top;
                            op_q <= bus.op;
                            if (bus.op == OP_DUP) begin
                                result <= bus.stk_top;
                                state  <= S_PUSH;
                            end else begin
                                state  <= S_WAIT_A;
                            end
                        end
                    end
                    S_WAIT_A: state <= (op_q == OP_DROP) ? S_DONE : S_POP_B;
                    S_POP_B: begin
                        b     <= bus.stk_top;
                        state <= S_WAIT_B;
                    end
                    S_WAIT_B: state <= S_EXEC;
                    S_EXEC: begin
                        if (op_q == OP_DIV || op_q == OP_MOD) begin
                            rem   <= rem_nx;
                            quo   <= q_nx;
                            cnt   <= 5'd1;
                            state <= S_DIV;
                        end else begin
                            result <= (op_q == OP_SWAP) ? a : alu;
                            state  <= S_PUSH;
                        end
                    end
                    S_DIV: begin
                        rem <= rem_nx;
                        quo <= q_nx;
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'd31) begin
                            result <= (op_q == OP_DIV) ? q_nx : rem_nx;
                            state  <= S_PUSH;
                        end
                    end
                    S_PUSH: state <= (op_q == OP_SWAP) ? S_GAP : S_DONE;
                    S_GAP: begin
                        result <= b;
                        state  <= S_PUSH_B;
                    end
                    S_PUSH_B: state <= S_DONE;
                    S_DONE:   state <= S_IDLE;
                    default:  state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_stack_op_sequencer.sv
// Bench for stack_op_sequencer: behavioural stack, expected-event scoreboard.
// Latency: n/a. Backpressure: n/a.
// Strobe/done/err events are queued with their expected cycle and checked as they appear.
module tb_stack_op_sequencer;
    localparam int W     = 32;
    localparam int SW    = 10;
    localparam int DEPTH = 1023;

    typedef struct {
        int          kind;   // 0 pop, 1 push, 2 done, 3 err
        int          cyc;
        logic [W-1:0] val;
    } ev_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    stack_op_sequencer_if #(.WIDTH(W), .SIZE_W(SW)) s ();

    stack_op_sequencer #(.WIDTH(W), .SIZE_W(SW), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (s)
    );

    logic [W-1:0]  mem [0:1023];
    logic [SW-1:0] sz;
    bit            ld;
    logic [SW-1:0] ld_sz;
    logic [W-1:0]  ld_below, ld_top;

    int  cyc = 0;
    int  t0 = 0;
    int  total = 0;
    int  bad = 0;
    bit  mon_en;
    bit  fin;
    int  cur_op;
    ev_t q[$];

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s (op %0d) got=%0h exp=%0h", tag, cur_op, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural stack driven by the DUT strobes.
    always @(posedge clk) begin
        if (ld) begin
            sz <= ld_sz;
            if (ld_sz >= SW'(1)) mem[ld_sz - SW'(1)] <= ld_top;
            if (ld_sz >= SW'(2)) mem[ld_sz - SW'(2)] <= ld_below;
        end else begin
            if (s.stk_push) begin
                mem[sz] <= s.stk_in;
                sz      <= sz + SW'(1);
            end
            if (s.stk_pop) sz <= sz - SW'(1);
        end
    end

    assign s.stk_size = sz;
    assign s.stk_top  = (sz != '0) ? mem[sz - SW'(1)] : '0;

    task automatic see(input int kind, input logic [W-1:0] val);
        ev_t e;
        int rel;
        rel = cyc - t0;
        if (q.size() == 0) begin
            chk("extra_evt", W'(kind), W'(7));
        end else begin
            e = q.pop_front();
            chk("evt_kind", W'(kind), W'(e.kind));
            chk("evt_cyc",  W'(rel),  W'(e.cyc));
            chk("evt_val",  val,      e.val);
        end
        if (kind >= 2) fin = 1'b1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (s.stk_pop)  see(0, '0);
            if (s.stk_push) see(1, s.stk_in);
            if (s.done)     see(2, '0);
            if (s.err)      see(3, W'(s.err_code));
        end
    end

    task automatic push_ev(input int kind, input int c, input logic [W-1:0] v);
        ev_t e;
        e.kind = kind; e.cyc = c; e.val = v;
        q.push_back(e);
    endtask

    task automatic load(input int n, input logic [W-1:0] below, input logic [W-1:0] top);
        ld_sz = SW'(n); ld_below = below; ld_top = top; ld = 1'b1;
        @(posedge clk); #1;
        ld = 1'b0;
    endtask

    // inj: 0 none, 1 stk_error at cycle 3, 2 reset at cycle 15, 3 stray start at cycle 2
    task automatic run_op(input logic [2:0] o, input int inj);
        logic [W-1:0] ta, tb_, r, e_top, e_nxt;
        logic [1:0]   code;
        int n, e_sz;
        bit chk_top, chk_nxt;
        cur_op = int'(o);
        n   = int'(sz);
        ta  = (n >= 1) ? mem[n-1] : '0;
        tb_ = (n >= 2) ? mem[n-2] : '0;
        code = 2'd0;
        case (o)
            3'b101:  if (n < 1) code = 2'd1;
            3'b111:  if (n < 1) code = 2'd1; else if (n >= DEPTH) code = 2'd3;
            default: if (n < 2) code = 2'd1; else if ((o == 3'b011 || o == 3'b100) && ta == '0) code = 2'd2;
        endcase
        e_sz = n; e_top = ta; e_nxt = tb_;
        chk_top = (n >= 1); chk_nxt = (n >= 2);
        r = '0;
        if (code != 2'd0) begin
            push_ev(3, 1, W'(code));
        end else if (inj == 1 || inj == 2) begin
            push_ev(0, 0, '0); push_ev(0, 2, '0);
            if (inj == 1) begin push_ev(3, 4, W'(3)); code = 2'd3; end
            e_sz = n - 2; chk_top = 1'b0; chk_nxt = 1'b0;
        end else begin
            case (o)
                3'b101: begin
                    push_ev(0, 0, '0); push_ev(2, 2, '0);
                    e_sz = n - 1; e_top = tb_; chk_top = (n >= 2); chk_nxt = 1'b0;
                end
                3'b111: begin
                    push_ev(1, 1, ta); push_ev(2, 2, '0);
                    e_sz = n + 1; e_top = ta; e_nxt = ta; chk_top = 1'b1; chk_nxt = 1'b1;
                end
                3'b110: begin
                    push_ev(0, 0, '0); push_ev(0, 2, '0);
                    push_ev(1, 5, ta); push_ev(1, 7, tb_); push_ev(2, 8, '0);
                    e_top = tb_; e_nxt = ta;
                end
                default: begin
                    case (o)
                        3'b000:  r = tb_ + ta;
                        3'b001:  r = tb_ - ta;
                        3'b010:  r = tb_ * ta;
                        3'b011:  r = tb_ / ta;
                        default: r = tb_ % ta;
                    endcase
                    push_ev(0, 0, '0); push_ev(0, 2, '0);
                    if (o == 3'b011 || o == 3'b100) begin
                        push_ev(1, 36, r); push_ev(2, 37, '0);
                    end else begin
                        push_ev(1, 5, r); push_ev(2, 6, '0);
                    end
                    e_sz = n - 1; e_top = r; chk_nxt = 1'b0;
                end
            endcase
        end

        fin = 1'b0;
        t0 = cyc;
        s.op = o;
        s.start = 1'b1;
        for (int k = 1; k <= 70; k++) begin
            @(posedge clk); #1;
            s.start     = (inj == 3 && k == 2);
            s.op        = (inj == 3 && k == 2) ? 3'b111 : o;
            s.stk_error = (inj == 1 && k == 3);
            if (k == 1) chk("busy_c1", W'(s.busy), W'(code == 2'd0 || inj == 1));
            if (inj == 2 && k == 15) reset_n = 1'b0;
            if (inj == 2 && k == 16) begin
                chk("rst_ctl", W'({s.busy, s.done, s.err, s.stk_push, s.stk_pop, s.err_code}), '0);
                chk("rst_stk_in", s.stk_in, '0);
                reset_n = 1'b1;
                fin = 1'b1;
            end
            if (fin) break;
        end
        chk("finished", W'(fin), W'(1));
        repeat (2) begin @(posedge clk); #1; end
        chk("leftover", W'(q.size()), '0);
        q.delete();
        chk("size", W'(sz), W'(e_sz));
        if (chk_top) chk("top", mem[sz - SW'(1)], e_top);
        if (chk_nxt) chk("next", mem[sz - SW'(2)], e_nxt);
        chk("err_code_hold", W'(s.err_code), W'(code));
        chk("busy_end", W'(s.busy), '0);
    endtask

    initial begin
        s.start = 1'b0; s.op = 3'b000; s.stk_error = 1'b0;
        mon_en = 1'b0; cur_op = -1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        load(0, '0, '0);
        repeat (2) begin @(posedge clk); #1; end
        chk("rst_ctl", W'({s.busy, s.done, s.err, s.stk_push, s.stk_pop, s.err_code}), '0);
        chk("rst_stk_in", s.stk_in, '0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;

        load(2, 7, 5);                        run_op(3'b000, 0);
        load(2, 100, 7);                      run_op(3'b011, 0);
        load(2, 100, 7);                      run_op(3'b100, 0);
        load(2, 9, 0);                        run_op(3'b011, 0);
        load(1, 0, 3);                        run_op(3'b000, 0);
        load(2, 1, 2);                        run_op(3'b110, 0);
                                              run_op(3'b111, 0);
        load(2, 32'hFFFF_FFFF, 2);            run_op(3'b000, 0);
        load(2, 3, 5);                        run_op(3'b001, 0);
        load(2, 6, 7);                        run_op(3'b010, 0);
        load(2, 32'h0001_0000, 32'h0001_0000); run_op(3'b010, 0);
        load(DEPTH, 1, 2);                    run_op(3'b111, 0);
        load(DEPTH, 1, 2);                    run_op(3'b101, 0);
        load(0, 0, 0);                        run_op(3'b101, 0);
        load(0, 0, 0);                        run_op(3'b111, 0);
        load(2, 32'hFFFF_FFFF, 1);            run_op(3'b011, 0);
        load(2, 32'hFFFF_FFFF, 16);           run_op(3'b100, 0);
        load(2, 4, 3);                        run_op(3'b000, 1);
        load(2, 100, 7);                      run_op(3'b011, 2);
        load(2, 100, 7);                      run_op(3'b011, 0);
        load(2, 7, 5);                        run_op(3'b000, 3);

        for (int i = 0; i < 8; i++) begin
            load(2, $urandom, $urandom_range(0, 40));
            run_op(3'($urandom_range(0, 7)), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
